// File: rtl/adder_tree_accum_ctrl.sv
// Frame reducer: a pipelined binary adder tree sums each beat, a tag pipe marks frame
// boundaries, and an accumulator emits one sum per frame. ADDER_ACCUM_ERR_EN adds dout_err.

module adder_tree #(
    parameter int DataBits = 8,
    parameter int NumWords = 4
) (
    input  logic                                  clk,
    input  logic                                  en,
    input  logic [DataBits*NumWords-1:0]          in_data,
    output logic [DataBits+$clog2(NumWords)-1:0]  sum
);
    localparam int Stages  = $clog2(NumWords);
    localparam int SumBits = DataBits + Stages;

    // Each level halves the operand count and registers its partial sums.
    for (genvar l = 0; l < Stages; l++) begin : g_lvl
        localparam int N = NumWords >> (l + 1);
        logic [SumBits-1:0] a [2*N];
        logic [SumBits-1:0] s [N];

        if (l == 0) begin : g_in
            always_comb begin
                for (int i = 0; i < 2*N; i++)
                    a[i] = SumBits'(in_data[i*DataBits +: DataBits]);
            end
        end else begin : g_prev
            assign a = g_lvl[l-1].s;
        end

        always_ff @(posedge clk) begin
            if (en) begin
                for (int i = 0; i < N; i++)
                    s[i] <= a[2*i] + a[2*i+1];
            end
        end
    end

    assign sum = g_lvl[Stages-1].s[0];
endmodule

module adder_tree_accum_ctrl #(
    parameter  int DataBits = 8,
    parameter  int NumWords = 4,
    parameter  int MaxBeats = 16,
    localparam int Stages   = $clog2(NumWords),
    localparam int SumBits  = DataBits + Stages,
    localparam int AccBits  = SumBits + $clog2(MaxBeats)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         din_last,
    input  logic [DataBits*NumWords-1:0] din_data,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [AccBits-1:0]           dout_data
`ifdef ADDER_ACCUM_ERR_EN
    ,
    output logic                         dout_err
`endif
);
    localparam int CntBits = $clog2(MaxBeats + 1);
    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_MID   = 1'b1;

    logic               advance;
    logic               accept;
    logic               eff_last;
    logic [0:0]         state;
    logic [CntBits-1:0] beat_cnt;
    logic [CntBits-1:0] beat_cnt_next;
    logic [Stages-1:0]  tag_valid;
    logic [Stages-1:0]  tag_first;
    logic [Stages-1:0]  tag_last;
    logic [SumBits-1:0] tree_sum;
    logic [AccBits-1:0] acc;
    logic [AccBits-1:0] acc_sum;
    logic               land_last;

    // A held output freezes the whole pipeline, so backpressure reaches the input.
    assign advance       = !(dout_valid && !dout_ready);
    assign din_ready     = advance && !rst;
    assign accept        = din_valid && din_ready;
    assign beat_cnt_next = (state == ST_FIRST) ? CntBits'(1) : beat_cnt + 1'b1;
    assign eff_last      = din_last || (beat_cnt_next == CntBits'(MaxBeats));

    adder_tree #(
        .DataBits (DataBits),
        .NumWords (NumWords)
    ) u_tree (
        .clk     (clk),
        .en      (advance),
        .in_data (din_data),
        .sum     (tree_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FIRST;
            beat_cnt <= '0;
        end else if (accept) begin
            if (eff_last) begin
                state    <= ST_FIRST;
                beat_cnt <= '0;
            end else begin
                state    <= ST_MID;
                beat_cnt <= beat_cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
        end else if (advance) begin
            tag_valid[0] <= accept;
            for (int k = 1; k < Stages; k++)
                tag_valid[k] <= tag_valid[k-1];
        end
    end

    // Frame markers travel alongside the tree so they line up with its output.
    always_ff @(posedge clk) begin
        if (advance) begin
            tag_first[0] <= (state == ST_FIRST);
            tag_last[0]  <= eff_last;
            for (int k = 1; k < Stages; k++) begin
                tag_first[k] <= tag_first[k-1];
                tag_last[k]  <= tag_last[k-1];
            end
        end
    end

`ifdef ADDER_ACCUM_ERR_EN
    logic [Stages-1:0] tag_err;

    always_ff @(posedge clk) begin
        if (advance) begin
            tag_err[0] <= !din_last && (beat_cnt_next == CntBits'(MaxBeats));
            for (int k = 1; k < Stages; k++)
                tag_err[k] <= tag_err[k-1];
        end
    end
`endif

    assign acc_sum   = (tag_first[Stages-1] ? '0 : acc) + AccBits'(tree_sum);
    assign land_last = tag_valid[Stages-1] && tag_last[Stages-1];

    // A landing result refills dout in the same cycle it is taken, so no bubble appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
`ifdef ADDER_ACCUM_ERR_EN
            dout_err   <= 1'b0;
`endif
        end else if (advance) begin
            if (land_last) begin
                dout_data  <= acc_sum;
                dout_valid <= 1'b1;
                acc        <= '0;
`ifdef ADDER_ACCUM_ERR_EN
                dout_err   <= tag_err[Stages-1];
`endif
            end else begin
                dout_valid <= 1'b0;
                if (tag_valid[Stages-1])
                    acc <= acc_sum;
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// Directed and randomized bench for adder_tree_accum_ctrl with 4x8-bit beats and 4-beat frames.
// A reference model predicts each frame sum; a negedge monitor scores every output handshake.

module tb_adder_tree_accum_ctrl;
    localparam int DataBits = 8;
    localparam int NumWords = 4;
    localparam int MaxBeats = 4;
    localparam int AccBits  = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               din_valid;
    logic               din_ready;
    logic               din_last;
    logic [31:0]        din_data;
    logic               dout_valid;
    logic               dout_ready;
    logic [AccBits-1:0] dout_data;
`ifdef ADDER_ACCUM_ERR_EN
    logic               dout_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int out_count    = 0;
    int stall_cycles = 0;
    int model_acc    = 0;
    int model_cnt    = 0;
    int exp_sum_q[$];
    bit exp_err_q[$];
    int out_log[$];
    bit rand_done;

    always #5 clk = ~clk;

    adder_tree_accum_ctrl #(
        .DataBits (DataBits),
        .NumWords (NumWords),
        .MaxBeats (MaxBeats)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_last   (din_last),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
`ifdef ADDER_ACCUM_ERR_EN
        ,
        .dout_err   (dout_err)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] beat(input logic [7:0] w3, input logic [7:0] w2,
                                         input logic [7:0] w1, input logic [7:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    // Present one beat, hold it until accepted, then fold it into the reference model.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int waited;
        int ws;
        din_valid = 1'b1;
        din_data  = data;
        din_last  = last;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!din_ready && waited < 1000);
        if (!din_ready)
            checkOutput("accept_timeout", din_ready, 1);
        stall_cycles += waited - 1;
        @(posedge clk);
        #1;
        ws = 0;
        for (int w = 0; w < NumWords; w++)
            ws += int'(data[w*DataBits +: DataBits]);
        model_acc += ws;
        model_cnt++;
        if (last || model_cnt == MaxBeats) begin
            exp_sum_q.push_back(model_acc);
            exp_err_q.push_back(!last);
            model_acc = 0;
            model_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        din_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_sum_q.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", exp_sum_q.size(), 0);
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            out_count++;
            out_log.push_back(int'(dout_data));
            checkOutput("out_pending", 32'(exp_sum_q.size() != 0), 1);
            if (exp_sum_q.size() != 0) begin
                checkOutput("out_sum", dout_data, exp_sum_q.pop_front());
`ifdef ADDER_ACCUM_ERR_EN
                checkOutput("out_err", dout_err, exp_err_q.pop_front());
`else
                void'(exp_err_q.pop_front());
`endif
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int waited;
        int n;
        logic [31:0] data;

        rst        = 1'b1;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        din_data   = '0;
        dout_ready = 1'b1;
        rand_done  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_din_ready", din_ready, 0);
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout_data", dout_data, 0);
`ifdef ADDER_ACCUM_ERR_EN
        checkOutput("rst_dout_err", dout_err, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_din_ready", din_ready, 1);
        @(posedge clk);
        #1;

        // Single-beat frame: result appears exactly three clocks after acceptance.
        applyStimulus(beat(4, 3, 2, 1), 1'b1);
        idle(0);
        @(negedge clk);
        checkOutput("t1_lat1_valid", dout_valid, 0);
        @(negedge clk);
        checkOutput("t1_lat2_valid", dout_valid, 0);
        @(negedge clk);
        checkOutput("t1_lat3_valid", dout_valid, 1);
        checkOutput("t1_data", dout_data, 10);
`ifdef ADDER_ACCUM_ERR_EN
        checkOutput("t1_err", dout_err, 0);
`endif
        drain();

        // Four back-to-back full-scale beats.
        base         = out_count;
        stall_cycles = 0;
        for (int b = 0; b < 4; b++)
            applyStimulus(beat(8'hff, 8'hff, 8'hff, 8'hff), b == 3);
        idle(0);
        checkOutput("t2_stalls", stall_cycles, 0);
        drain();
        checkOutput("t2_out_count", out_count - base, 1);
        if (out_count > base)
            checkOutput("t2_sum", out_log[base], 4080);

        // Two single-beat frames under downstream backpressure.
        base       = out_count;
        dout_ready = 1'b0;
        applyStimulus(beat(1, 1, 1, 1), 1'b1);
        applyStimulus(beat(2, 2, 2, 2), 1'b1);
        idle(0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!dout_valid && waited < 20);
        checkOutput("t3_valid", dout_valid, 1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0)
                @(negedge clk);
            checkOutput("t3_hold_valid", dout_valid, 1);
            checkOutput("t3_hold_data", dout_data, 4);
            checkOutput("t3_stall_ready", din_ready, 0);
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        drain();
        checkOutput("t3_out_count", out_count - base, 2);
        if (out_count >= base + 2) begin
            checkOutput("t3_first", out_log[base], 4);
            checkOutput("t3_second", out_log[base+1], 8);
        end

        // Five-beat frame is cut at four beats; the fifth opens its own frame.
        base = out_count;
        for (int b = 0; b < 5; b++)
            applyStimulus(beat(0, 0, 0, 1), b == 4);
        idle(0);
        drain();
        checkOutput("t4_out_count", out_count - base, 2);
        if (out_count >= base + 2) begin
            checkOutput("t4_forced", out_log[base], 4);
            checkOutput("t4_tail", out_log[base+1], 1);
        end

        // Reset mid-frame discards the partial sum.
        base = out_count;
        applyStimulus(beat(1, 2, 3, 4), 1'b0);
        applyStimulus(beat(1, 1, 1, 1), 1'b0);
        idle(0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_ready", din_ready, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        model_acc = 0;
        model_cnt = 0;
        @(negedge clk);
        checkOutput("t5_post_rst_valid", dout_valid, 0);
        @(posedge clk);
        #1;
        applyStimulus(beat(5, 5, 5, 5), 1'b1);
        idle(0);
        drain();
        checkOutput("t5_out_count", out_count - base, 1);
        if (out_count > base)
            checkOutput("t5_sum", out_log[base], 20);

        // Random frames with input gaps and random downstream readiness.
        base = out_count;
        fork
            begin
                for (int f = 0; f < 1000; f++) begin
                    n = $urandom_range(1, 4);
                    for (int b = 0; b < n; b++) begin
                        if ($urandom_range(0, 3) == 0)
                            idle($urandom_range(1, 2));
                        for (int w = 0; w < NumWords; w++)
                            data[w*DataBits +: DataBits] = 8'($urandom_range(0, 255));
                        applyStimulus(data, b == n - 1);
                    end
                end
                idle(0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    dout_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        dout_ready = 1'b1;
        drain();
        checkOutput("t6_out_count", out_count - base, 1000);
        checkOutput("leftover", exp_sum_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
